btb_assoc: RTL and testbench
============================

# btb_assoc

Parametrised set-associative branch target buffer with saturating-counter direction prediction for the 5-stage pipeline. Looks up PCF combinationally in IF to supply a predicted next PC. Carries the prediction through ID and EX under the pipeline's stall/flush controls. Resolves the prediction against the EX-stage branch outcome, raising redirect/flush requests and updating its tables.

## Interface
- SET_ADDR_LEN, 6: log2 of set count; index = PC[SET_ADDR_LEN+1:2], tag = PC[31:SET_ADDR_LEN+2]
- WAYS, 2: associativity; legal values 1, 2, 4
- CNT_BITS, 2: width of per-entry saturating counter (legal 1..3); predict taken when MSB = 1
- CNT_INIT, 2'b10: counter value written on allocation (weakly taken)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- PCF  in  32  IF-stage PC
- BranchTypeE  in  3  EX instruction branch type; 0 = not a control transfer
- BranchE  in  1  EX control transfer resolved taken
- BranchTarget  in  32  EX resolved target
- StallD, StallE  in  1  hold ID / EX pipeline registers
- FlushD, FlushE  in  1  bubble into ID / EX pipeline registers
- PC_PRE  out  32  predicted target; hit-way target on hit, else 0
- PC_SEL  out  1  use PC_PRE as next PC (hit and counter MSB = 1)
- btb_prefail  out  1  EX: predicted taken, actually not taken; redirect to PCE+4
- btb_fill  out  1  EX: predicted not taken, actually taken; redirect to BranchTarget
- btb_retarget  out  1  EX: predicted taken, taken, predicted target != BranchTarget
- btb_flush  out  1  OR of the three above
- PCE  out  32  EX-stage PC tracked by this block

## Operation
- Storage per set, per way: valid, tag, 32-bit target, CNT_BITS counter. Per set: round-robin victim pointer of log2(WAYS) bits (absent when WAYS = 1).
- IF lookup: hit = some way with valid set and matching tag. Tags are never duplicated within a set, so at most one way hits.
- Pipeline tracking:
  - Per stage registers: valid, PC, predicted-taken, predicted target.
  - When !StallD, the ID register loads the IF values, or zeros if FlushD.
  - When !StallE, the EX register loads the ID values, or zeros if FlushE.
  - Stall holds. Flush wins over load. Flush while stalled has no effect.
- Resolution, combinational from the EX register; all outputs are 0 when EX valid = 0:
  - prefail = predT & !BranchE.
  - fill = !predT & BranchE.
  - retarget = predT & BranchE & (predTarget != BranchTarget).
- Update happens when EX valid and !StallE, independent of FlushE. It uses a second, EX-time lookup of PCE, not the IF-time hit.
  - Hit, BranchTypeE != 0: counter saturating +1 if BranchE, else −1. If BranchE, target <= BranchTarget.
  - Hit, BranchTypeE = 0: clear that way's valid (aliased entry).
  - Miss, BranchTypeE != 0, BranchE: allocate a victim with valid = 1, tag, target = BranchTarget, counter = CNT_INIT.
    - Victim is the lowest-index invalid way if any exists; otherwise the way at the set's pointer.
    - The pointer advances by 1 mod WAYS only when a valid way is replaced.
  - Miss, not taken: no write.
- The EX-time re-lookup prevents duplicate allocation when two in-flight copies of one PC both missed in IF.
- Counters saturate: no wrap at 0 or 2^CNT_BITS−1.

## Timing
- Reset clears all valid bits, counters, targets, tags, victim pointers and pipeline registers.
- Reset values: PC_PRE = 0, PC_SEL = 0, PCE = 0, all flush/redirect outputs 0. Reset mid-operation discards all in-flight state immediately.
- IF lookup is zero-latency combinational from PCF.
- Resolution outputs are combinational from the EX register in the same cycle.
- Table writes take effect at the posedge ending the update cycle.
  - A same-cycle IF lookup of the set being written sees the old contents.
  - The next cycle sees the new contents.
- A branch predicted in IF reaches EX 2 cycles later absent stalls. Stalls extend this by holding registers.
- StallE holds both the EX register and the update, so the update is performed exactly once per EX instruction.

## Test plan
- Reset, then PCF = 0x100: PC_SEL = 0, PC_PRE = 0. Taken branch at 0x100 → 0x200 in EX: btb_fill = 1, btb_flush = 1. Next lookup of 0x100 gives PC_SEL = 1, PC_PRE = 0x200.
- Same branch not taken once: btb_prefail = 1 and the counter goes 10→01. Next lookup gives PC_SEL = 0 with PC_PRE still 0x200. Saturation: four further not-taken updates leave the counter at 00.
- Taken branch at 0x100 hits, predicted 0x200, resolves to 0x300: btb_retarget = 1, btb_prefail = 0, btb_fill = 0. Next lookup gives PC_PRE = 0x300.
- WAYS = 2, SET_ADDR_LEN = 6: allocate taken branches at 0x100, 0x200, 0x300 (same set). Required: 0x100 and 0x200 fill ways 0 and 1; 0x300 replaces way 0 (pointer 0→1); 0x200 still hits and 0x100 misses.
- Non-branch (BranchTypeE = 0) at a PC that hits predicted-taken: btb_prefail = 1 and the entry is invalidated. Next lookup misses.
- StallE high for 3 cycles with a taken branch in EX: the counter increments exactly once. FlushD during a hit: the ID register is zeroed, and 2 cycles later no redirect output asserts.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with saturating-counter direction prediction.
// Predicts in IF, carries the prediction through ID/EX, and resolves/updates in EX.
module btb_assoc #(
  parameter int SET_ADDR_LEN = 6,
  parameter int WAYS = 2,
  parameter int CNT_BITS = 2,
  parameter logic [CNT_BITS-1:0] CNT_INIT = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        StallD,
  input  logic        StallE,
  input  logic        FlushD,
  input  logic        FlushE,
  output logic [31:0] PC_PRE,
  output logic        PC_SEL,
  output logic        btb_prefail,
  output logic        btb_fill,
  output logic        btb_retarget,
  output logic        btb_flush,
  output logic [31:0] PCE
);
  localparam int SETS  = 1 << SET_ADDR_LEN;
  localparam int TAG_W = 30 - SET_ADDR_LEN;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [SETS-1:0][WAYS-1:0]               valid_q;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]    tag_q;
  logic [SETS-1:0][WAYS-1:0][31:0]         tgt_q;
  logic [SETS-1:0][WAYS-1:0][CNT_BITS-1:0] cnt_q;
  logic [SETS-1:0][WAY_W-1:0]              ptr_q;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (&c) ? c : c + CNT_BITS'(1);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] c);
    return (|c) ? c - CNT_BITS'(1) : c;
  endfunction

  // IF stage: combinational lookup of PCF
  logic [SET_ADDR_LEN-1:0] idx_f;
  logic [TAG_W-1:0]        tag_f;
  logic                    hit_f;
  logic [WAY_W-1:0]        way_f;

  assign idx_f = PCF[SET_ADDR_LEN+1:2];
  assign tag_f = PCF[31:SET_ADDR_LEN+2];

  always_comb begin
    hit_f = 1'b0;
    way_f = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_f][w] && tag_q[idx_f][w] == tag_f) begin
        hit_f = 1'b1;
        way_f = WAY_W'(w);
      end
    end
  end

  assign PC_PRE = hit_f ? tgt_q[idx_f][way_f] : 32'd0;
  assign PC_SEL = hit_f & cnt_q[idx_f][way_f][CNT_BITS-1];

  // ID / EX stage prediction tracking
  logic        vld_p1, pt_p1, vld_p2, pt_p2;
  logic [31:0] pc_p1, tgt_p1, pc_p2, tgt_p2;

  assign PCE = pc_p2;

  // EX stage: resolution and re-lookup of PCE for the update
  assign btb_prefail  = vld_p2 & pt_p2 & ~BranchE;
  assign btb_fill     = vld_p2 & ~pt_p2 & BranchE;
  assign btb_retarget = vld_p2 & pt_p2 & BranchE & (tgt_p2 != BranchTarget);
  assign btb_flush    = btb_prefail | btb_fill | btb_retarget;

  logic [SET_ADDR_LEN-1:0] idx_e;
  logic [TAG_W-1:0]        tag_e;
  logic                    hit_e, inv_found, upd;
  logic [WAY_W-1:0]        way_e, inv_way, victim;

  assign idx_e = pc_p2[SET_ADDR_LEN+1:2];
  assign tag_e = pc_p2[31:SET_ADDR_LEN+2];
  assign upd   = vld_p2 & ~StallE;

  always_comb begin
    hit_e     = 1'b0;
    way_e     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx_e][w] && tag_q[idx_e][w] == tag_e) begin
        hit_e = 1'b1;
        way_e = WAY_W'(w);
      end
    end
    // Scan downward so the lowest-index invalid way wins
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_e][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim = inv_found ? inv_way : ptr_q[idx_e];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      vld_p1  <= 1'b0;
      pt_p1   <= 1'b0;
      pc_p1   <= '0;
      tgt_p1  <= '0;
      vld_p2  <= 1'b0;
      pt_p2   <= 1'b0;
      pc_p2   <= '0;
      tgt_p2  <= '0;
    end else begin
      if (!StallD) begin
        vld_p1 <= ~FlushD;
        pt_p1  <= FlushD ? 1'b0  : PC_SEL;
        pc_p1  <= FlushD ? 32'd0 : PCF;
        tgt_p1 <= FlushD ? 32'd0 : PC_PRE;
      end
      if (!StallE) begin
        vld_p2 <= FlushE ? 1'b0  : vld_p1;
        pt_p2  <= FlushE ? 1'b0  : pt_p1;
        pc_p2  <= FlushE ? 32'd0 : pc_p1;
        tgt_p2 <= FlushE ? 32'd0 : tgt_p1;
      end
      if (upd) begin
        if (hit_e) begin
          if (BranchTypeE != 3'd0) begin
            cnt_q[idx_e][way_e] <= BranchE ? sat_inc(cnt_q[idx_e][way_e])
                                           : sat_dec(cnt_q[idx_e][way_e]);
            if (BranchE) tgt_q[idx_e][way_e] <= BranchTarget;
          end else begin
            valid_q[idx_e][way_e] <= 1'b0;
          end
        end else if (BranchTypeE != 3'd0 && BranchE) begin
          valid_q[idx_e][victim] <= 1'b1;
          tag_q[idx_e][victim]   <= tag_e;
          tgt_q[idx_e][victim]   <= BranchTarget;
          cnt_q[idx_e][victim]   <= CNT_INIT;
          if (!inv_found && WAYS > 1) ptr_q[idx_e] <= ptr_q[idx_e] + WAY_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_btb_assoc.sv
// Directed testbench for btb_assoc: allocation, counters, retarget, replacement,
// aliasing invalidation, stall/flush handling and reset.
module tb_btb_assoc;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, BranchTarget, PC_PRE, PCE;
  logic [2:0]  BranchTypeE;
  logic        BranchE, StallD, StallE, FlushD, FlushE;
  logic        PC_SEL, btb_prefail, btb_fill, btb_retarget, btb_flush;

  localparam logic [31:0] DUMMY = 32'h0000_0f04;

  int checks = 0;
  int errors = 0;

  btb_assoc dut (
    .clk(clk), .rst(rst), .PCF(PCF), .BranchTypeE(BranchTypeE), .BranchE(BranchE),
    .BranchTarget(BranchTarget), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
    .FlushE(FlushE), .PC_PRE(PC_PRE), .PC_SEL(PC_SEL), .btb_prefail(btb_prefail),
    .btb_fill(btb_fill), .btb_retarget(btb_retarget), .btb_flush(btb_flush), .PCE(PCE)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_ex(input string nm, input logic [31:0] pc,
                          input logic ep, input logic ef, input logic er);
    check_eq({nm, ".pce"},      PCE,          pc);
    check_eq({nm, ".prefail"},  btb_prefail,  ep);
    check_eq({nm, ".fill"},     btb_fill,     ef);
    check_eq({nm, ".retarget"}, btb_retarget, er);
    check_eq({nm, ".flush"},    btb_flush,    ep | ef | er);
  endtask

  // One isolated instruction: IF lookup, a dummy cycle, then EX resolution and update
  task automatic xact(input string nm, input logic [31:0] pc, input logic [2:0] bt,
                      input logic tk, input logic [31:0] tg, input logic exp_sel,
                      input logic [31:0] exp_pre, input logic ep, input logic ef,
                      input logic er);
    @(negedge clk);
    PCF = pc;
    #1;
    check_eq({nm, ".sel"}, PC_SEL, exp_sel);
    check_eq({nm, ".pre"}, PC_PRE, exp_pre);
    @(negedge clk);
    PCF = DUMMY;
    @(negedge clk);
    BranchTypeE = bt; BranchE = tk; BranchTarget = tg;
    #1;
    check_ex(nm, pc, ep, ef, er);
    @(posedge clk);
    #1;
    BranchTypeE = 3'd0; BranchE = 1'b0; BranchTarget = 32'd0;
  endtask

  initial begin
    rst = 1'b1; PCF = 32'h100; BranchTypeE = 3'd0; BranchE = 1'b0; BranchTarget = 32'd0;
    StallD = 1'b0; StallE = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset.sel", PC_SEL, 1'b0);
    check_eq("reset.pre", PC_PRE, 32'd0);
    check_ex("reset", 32'd0, 1'b0, 1'b0, 1'b0);

    // Allocation, counter decrement and saturation, then retarget
    xact("alloc",   32'h100, 3'd1, 1'b1, 32'h200, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0);
    xact("nt1",     32'h100, 3'd1, 1'b0, 32'h104, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    xact("nt2",     32'h100, 3'd1, 1'b0, 32'h104, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
    xact("nt3",     32'h100, 3'd1, 1'b0, 32'h104, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
    xact("nt4",     32'h100, 3'd1, 1'b0, 32'h104, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
    xact("nt5",     32'h100, 3'd1, 1'b0, 32'h104, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0);
    xact("sat_t1",  32'h100, 3'd1, 1'b1, 32'h200, 1'b0, 32'h200, 1'b0, 1'b1, 1'b0);
    xact("sat_t2",  32'h100, 3'd1, 1'b1, 32'h200, 1'b0, 32'h200, 1'b0, 1'b1, 1'b0);
    xact("retgt",   32'h100, 3'd1, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    xact("newtgt",  32'h100, 3'd1, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);

    // Reset with 0x100 in flight discards pipeline and tables at once
    @(negedge clk);
    PCF = 32'h100;
    @(negedge clk);
    PCF = DUMMY;
    @(negedge clk);
    BranchTypeE = 3'd1; BranchE = 1'b1; BranchTarget = 32'h300;
    #1;
    check_eq("inflight.pce", PCE, 32'h100);
    rst = 1'b1;
    #1;
    check_ex("midreset", 32'd0, 1'b0, 1'b0, 1'b0);
    PCF = 32'h100;
    #1;
    check_eq("midreset.sel", PC_SEL, 1'b0);
    check_eq("midreset.pre", PC_PRE, 32'd0);
    @(negedge clk);
    rst = 1'b0; BranchTypeE = 3'd0; BranchE = 1'b0; BranchTarget = 32'd0;

    // Two-way replacement in set 0
    xact("a100",    32'h100, 3'd1, 1'b1, 32'h500, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0);
    xact("a200",    32'h200, 3'd1, 1'b1, 32'h600, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0);
    xact("a300",    32'h300, 3'd1, 1'b1, 32'h700, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0);
    xact("h300",    32'h300, 3'd1, 1'b1, 32'h700, 1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
    xact("h200",    32'h200, 3'd1, 1'b1, 32'h600, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    xact("m100",    32'h100, 3'd1, 1'b0, 32'h104, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0);
    xact("a400",    32'h400, 3'd1, 1'b1, 32'h800, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0);
    xact("m200",    32'h200, 3'd1, 1'b0, 32'h204, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0);

    // Non-branch aliasing a predicted-taken entry
    xact("alias",   32'h300, 3'd0, 1'b0, 32'h000, 1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
    xact("aliasm",  32'h300, 3'd1, 1'b0, 32'h304, 1'b0, 32'h000, 1'b0, 1'b0, 1'b0);

    // StallE for 3 cycles: counter 01 must become 10, not saturate at 11
    xact("wk400",   32'h400, 3'd1, 1'b0, 32'h404, 1'b1, 32'h800, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    PCF = 32'h400;
    #1;
    check_eq("stall.sel", PC_SEL, 1'b0);
    @(negedge clk);
    PCF = DUMMY;
    @(negedge clk);
    BranchTypeE = 3'd1; BranchE = 1'b1; BranchTarget = 32'h800;
    StallD = 1'b1; StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ex("stall", 32'h400, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    StallD = 1'b0; StallE = 1'b0;
    @(posedge clk);
    #1;
    BranchTypeE = 3'd0; BranchE = 1'b0; BranchTarget = 32'd0;
    xact("poststl1", 32'h400, 3'd1, 1'b0, 32'h404, 1'b1, 32'h800, 1'b1, 1'b0, 1'b0);
    xact("poststl2", 32'h400, 3'd1, 1'b0, 32'h404, 1'b0, 32'h800, 1'b0, 1'b0, 1'b0);

    // FlushD while a predicted-taken hit is in IF
    xact("a600",    32'h600, 3'd1, 1'b1, 32'h900, 1'b0, 32'h000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    PCF = 32'h600; FlushD = 1'b1;
    #1;
    check_eq("flushd.sel", PC_SEL, 1'b1);
    check_eq("flushd.pre", PC_PRE, 32'h900);
    @(negedge clk);
    PCF = DUMMY; FlushD = 1'b0;
    @(negedge clk);
    BranchTypeE = 3'd1; BranchE = 1'b0; BranchTarget = 32'd0;
    #1;
    check_ex("flushd", 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    BranchTypeE = 3'd0;
    xact("h600",    32'h600, 3'd1, 1'b1, 32'h900, 1'b1, 32'h900, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
